// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder: FSM state encoding,
// latency bound and the address legality check.
package dmem_responder_pkg;

    localparam int WORD_W      = 32;
    localparam int BE_W        = WORD_W / 8;
    localparam int MAX_LATENCY = 7;
    localparam int CNT_W       = $clog2(MAX_LATENCY + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Misaligned or beyond the last stored word; out-of-range never aliases onto a low word.
    function automatic logic addr_is_err(input logic [WORD_W-1:0] addr, input int depth_words);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[WORD_W-1:2]} >= 32'(depth_words));
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte write enables and a registered read port.
// Writes and reads are mutually exclusive per cycle; the caller guarantees a legal index.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic [BE_W-1:0]   wr_be_i,
    input  logic              rd_en_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
    logic [WORD_W-1:0] rdata_q;

    // NOTE: the array has no reset so it maps onto RAM and keeps its contents across rst;
    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BE_W; b++) begin
            if (wr_be_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (rd_en_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding memory responder: accepts one load/store, waits LATENCY cycles,
// commits to the array on the edge entering RESP and holds the response until taken.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int              AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam bit              DIRECT_RESP = (LATENCY <= 1);
    localparam logic [CNT_W-1:0] CNT_INIT   = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic              rd_ok_q;
    logic              wr_q;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;

    logic              req_fire;
    logic              commit;
    logic              eff_wr;
    logic              eff_err;
    logic [WORD_W-1:0] eff_addr;
    logic [WORD_W-1:0] eff_wdata;
    logic [BE_W-1:0]   eff_be;
    logic [BE_W-1:0]   arr_be;
    logic              arr_rd_en;
    logic [WORD_W-1:0] arr_rdata;

    // With LATENCY=1 the commit edge is the accept edge, so the live request feeds the array.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        eff_wr    = wr_q;
        eff_addr  = addr_q;
        eff_wdata = wdata_q;
        eff_be    = be_q;
        if (state_q == ST_IDLE) begin
            eff_wr    = req_wr;
            eff_addr  = req_addr;
            eff_wdata = req_wdata;
            eff_be    = req_be;
        end
        eff_err   = addr_is_err(eff_addr, DEPTH_WORDS);
        req_fire  = req_valid && req_ready_q;
        commit    = (DIRECT_RESP && req_fire) || ((state_q == ST_WAIT) && (cnt_q == '0));
        arr_be    = (commit && eff_wr && !eff_err) ? eff_be : '0;
        arr_rd_en = commit && !eff_wr && !eff_err;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rd_ok_q     <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_fire) begin
                        req_ready_q <= 1'b0;
                        wr_q        <= req_wr;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        be_q        <= req_be;
                        if (DIRECT_RESP) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= eff_err;
                            rd_ok_q     <= !eff_wr && !eff_err;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= eff_err;
                        rd_ok_q     <= !eff_wr && !eff_err;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rd_ok_q     <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk     (clk),
        .wr_be_i (arr_be),
        .rd_en_i (arr_rd_en),
        .addr_i  (eff_addr[2 +: AW]),
        .wdata_i (eff_wdata),
        .rdata_o (arr_rdata)
    );

    // The read register only loads on a good load, so masking yields 0 for stores and errors.
    assign rsp_rdata = rd_ok_q ? arr_rdata : '0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign req_ready = req_ready_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 runs LATENCY=2, instance 1 runs LATENCY=1,
// both 1024 words, checked against a simple word-array reference model.
module tb_dmem_responder;

    localparam int DEPTH = 1024;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_wr    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];
    logic        busy      [2];

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] ref_mem [2][DEPTH];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dmem_responder #(
            .DEPTH_WORDS (DEPTH),
            .LATENCY     ((g == 0) ? 2 : 1)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_wr    (req_wr[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .req_be    (req_be[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g]),
            .busy      (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic int lat_of(input int u);
        return (u == 0) ? 2 : 1;
    endfunction

    // Reference: word array, error = misaligned or word number past the end.
    function automatic void model(input int u, input bit wr, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] be,
                                  output logic [31:0] exp_rd, output logic exp_err);
        int unsigned word;
        word    = addr / 4;
        exp_err = ((addr % 4) != 0) || (word >= DEPTH);
        exp_rd  = '0;
        if (!exp_err) begin
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[u][word][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                exp_rd = ref_mem[u][word];
            end
        end
    endfunction

    // One transaction; starts and ends on a negedge. During 'hold' cycles the response is
    // stalled while a conflicting store is offered, which must be ignored.
    task automatic xact(input int u, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int hold,
                        output logic [31:0] rdata, output logic err);
        int n;
        int lat;
        rdata = '0;
        err   = 1'b0;
        req_wr[u] = wr; req_addr[u] = addr; req_wdata[u] = wdata; req_be[u] = be;
        req_valid[u] = 1'b1;
        n = 0;
        while (req_ready[u] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (req_ready[u] !== 1'b1) begin
            check("accept_timeout", 32'(req_ready[u]), 32'd1);
            req_valid[u] = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid[u] = 1'b0;
        req_wr[u]    = 1'($urandom);
        req_addr[u]  = $urandom;
        req_wdata[u] = $urandom;
        req_be[u]    = 4'($urandom);
        lat = 1;
        while (rsp_valid[u] !== 1'b1 && lat <= 20) begin
            rsp_ready[u] = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        rsp_ready[u] = 1'b0;
        check($sformatf("latency_u%0d", u), 32'(lat), 32'(lat_of(u)));
        if (rsp_valid[u] !== 1'b1) return;
        rdata = rsp_rdata[u];
        err   = rsp_err[u];
        for (int h = 0; h < hold; h++) begin
            req_valid[u] = 1'b1; req_wr[u] = 1'b1; req_addr[u] = 32'h10;
            req_wdata[u] = 32'h0; req_be[u] = 4'hF;
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid[u]), 32'd1);
            check("hold_rdata", rsp_rdata[u], rdata);
            check("hold_err",   32'(rsp_err[u]), 32'(err));
            check("hold_req_ready", 32'(req_ready[u]), 32'd0);
        end
        req_valid[u] = 1'b0;
        rsp_ready[u] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[u] = 1'b0;
        check("rsp_done_valid", 32'(rsp_valid[u]), 32'd0);
        check("rsp_done_ready", 32'(req_ready[u]), 32'd1);
    endtask

    vec_t        vecs [22];
    logic [31:0] rd, exp_rd;
    logic        er, exp_er;

    initial begin
        vecs[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h10,       32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h10,       32'h0000CAFE, 4'h3, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 32'h10,       32'h0,        4'h0, 32'hDEADCAFE, 1'b0};
        vecs[4]  = '{1'b0, 32'h13,       32'h0,        4'hF, 32'h0,        1'b1};
        vecs[5]  = '{1'b0, 32'h1000,     32'h0,        4'hF, 32'h0,        1'b1};
        vecs[6]  = '{1'b0, 32'h10,       32'h0,        4'h0, 32'hDEADCAFE, 1'b0};
        vecs[7]  = '{1'b1, 32'h0,        32'h01020304, 4'hF, 32'h0,        1'b0};
        vecs[8]  = '{1'b1, 32'h1000,     32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        vecs[9]  = '{1'b1, 32'h2,        32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        vecs[10] = '{1'b0, 32'h0,        32'h0,        4'h0, 32'h01020304, 1'b0};
        vecs[11] = '{1'b1, 32'h14,       32'hAABBCCDD, 4'hF, 32'h0,        1'b0};
        vecs[12] = '{1'b1, 32'h14,       32'h12345678, 4'h0, 32'h0,        1'b0};
        vecs[13] = '{1'b0, 32'h14,       32'h0,        4'h0, 32'hAABBCCDD, 1'b0};
        vecs[14] = '{1'b1, 32'hFFC,      32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
        vecs[15] = '{1'b0, 32'hFFC,      32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
        vecs[16] = '{1'b1, 32'h20,       32'h11111111, 4'hF, 32'h0,        1'b0};
        vecs[17] = '{1'b0, 32'h20,       32'h0,        4'h0, 32'h11111111, 1'b0};
        vecs[18] = '{1'b1, 32'h18,       32'hA5A5A5A5, 4'hF, 32'h0,        1'b0};
        vecs[19] = '{1'b1, 32'h18,       32'h5A5A5A5A, 4'hA, 32'h0,        1'b0};
        vecs[20] = '{1'b0, 32'h18,       32'h0,        4'h0, 32'h5AA55AA5, 1'b0};
        vecs[21] = '{1'b0, 32'hFFFFFFFC, 32'h0,        4'h0, 32'h0,        1'b1};

        rst = 1'b0;
        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 1'b0; req_wr[u] = 1'b0; req_addr[u] = '0;
            req_wdata[u] = '0;   req_be[u] = '0;   rsp_ready[u] = 1'b0;
        end

        // Reset state and first-edge ready
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check("rst_rsp_valid", 32'(rsp_valid[u]), 32'd0);
            check("rst_rsp_rdata", rsp_rdata[u], 32'd0);
            check("rst_rsp_err",   32'(rsp_err[u]), 32'd0);
            check("rst_busy",      32'(busy[u]), 32'd0);
            check("rst_req_ready", 32'(req_ready[u]), 32'd0);
        end
        rst = 1'b1;
        #1 check("ready_before_edge", 32'(req_ready[0]), 32'd0);
        @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) check("ready_after_edge", 32'(req_ready[u]), 32'd1);
        @(negedge clk);

        // Preload a 64-word window on both instances
        for (int u = 0; u < 2; u++) begin
            for (int w = 0; w < 64; w++) begin
                logic [31:0] d;
                d = $urandom;
                model(u, 1'b1, 32'(w * 4), d, 4'hF, exp_rd, exp_er);
                xact(u, 1'b1, 32'(w * 4), d, 4'hF, 0, rd, er);
            end
        end

        // Directed vector table on the LATENCY=2 instance
        for (int i = 0; i < 22; i++) begin
            model(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, exp_rd, exp_er);
            xact(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, 0, rd, er);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
        end

        // Stalled response with a competing request offered meanwhile
        xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, rd, er);
        check("stall_rdata", rd, 32'hDEADCAFE);
        check("stall_busy_after", 32'(busy[0]), 32'd0);
        xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
        check("stall_no_store", rd, 32'hDEADCAFE);

        // Reset during WAIT of a store to 0x20 discards it
        req_wr[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'h99999999; req_be[0] = 4'hF;
        req_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("midrst_busy_before", 32'(busy[0]), 32'd1);
        rst = 1'b0;
        #1;
        check("midrst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("midrst_rsp_rdata", rsp_rdata[0], 32'd0);
        check("midrst_rsp_err",   32'(rsp_err[0]), 32'd0);
        check("midrst_busy",      32'(busy[0]), 32'd0);
        check("midrst_req_ready", 32'(req_ready[0]), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 check("midrst_ready_back", 32'(req_ready[0]), 32'd1);
        @(negedge clk);
        xact(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er);
        check("midrst_mem_kept", rd, 32'h11111111);

        // LATENCY=1 back-to-back loads with rsp_ready held high
        begin
            logic [31:0] exp_q [$];
            int idx, got, last_t;
            bit pending;
            idx = 0; got = 0; last_t = -1; pending = 1'b0;
            rsp_ready[1] = 1'b1; req_wr[1] = 1'b0; req_be[1] = 4'h0; req_wdata[1] = '0;
            req_addr[1] = 32'h0; req_valid[1] = 1'b1;
            for (int t = 0; t < 60 && got < 8; t++) begin
                if (rsp_valid[1] === 1'b1) begin
                    if (exp_q.size() > 0) check("b2b_rdata", rsp_rdata[1], exp_q.pop_front());
                    else check("b2b_unexpected_rsp", 32'(rsp_valid[1]), 32'd0);
                    if (last_t >= 0) check("b2b_gap", 32'(t - last_t), 32'd2);
                    last_t = t;
                    got++;
                end
                if (pending) begin
                    pending = 1'b0;
                    idx++;
                    if (idx < 8) req_addr[1] = 32'(idx * 4);
                    else req_valid[1] = 1'b0;
                end
                if (req_valid[1] && req_ready[1] === 1'b1) begin
                    exp_q.push_back(ref_mem[1][idx]);
                    pending = 1'b1;
                end
                @(negedge clk);
            end
            req_valid[1] = 1'b0;
            rsp_ready[1] = 1'b0;
            check("b2b_count", 32'(got), 32'd8);
            @(negedge clk);
        end

        // Randomized traffic against the reference model
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 80; i++) begin
                int unsigned r;
                bit          wr;
                logic [31:0] addr, wdata;
                logic [3:0]  be;
                r     = $urandom_range(0, 9);
                wr    = 1'($urandom);
                wdata = $urandom;
                be    = 4'($urandom);
                if (r < 7)       addr = 32'($urandom_range(0, 63) * 4);
                else if (r == 7) addr = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
                else if (r == 8) addr = 32'((DEPTH + $urandom_range(0, 4000)) * 4);
                else             addr = (u == 0) ? 32'hFFC : 32'h0;
                model(u, wr, addr, wdata, be, exp_rd, exp_er);
                xact(u, wr, addr, wdata, be, $urandom_range(0, 2), rd, er);
                check($sformatf("rand_u%0d_rdata", u), rd, exp_rd);
                check($sformatf("rand_u%0d_err", u), 32'(er), 32'(exp_er));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
